// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage.
//   - Data, address and register-index widths
//   - FSM state encoding for the wait sequencer
//   - Read-data value returned when an access times out
//   - Memory request payload and the access-condition helper
package mem_stage_pkg;

  localparam int unsigned DW          = 16;
  localparam int unsigned AW          = 16;
  localparam int unsigned RW          = 4;
  localparam int unsigned TMO_CYC_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [DW-1:0] TIMEOUT_DATA = DW'(16'hFFFF);

  // Request payload presented to data memory
  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

  // A valid (non-bubble) instruction that loads or stores
  function automatic logic is_access(input logic inval, input logic rd, input logic wr);
    return ~inval & (rd | wr);
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Wait sequencer for the memory stage: tracks an outstanding data-memory
// access, captures its read data and raises the pipeline stall.
// Optional feature macro: MEM_TIMEOUT_EN (abandons a WAIT after TMO_CYC
// cycles, returns TIMEOUT_DATA and sets sticky mem_err).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   acc             current EX instruction needs memory
//   is_store        current EX instruction is a store
//   mem_ready       memory completes the request this cycle
//   mem_rdata       memory read data
//   state           current sequencer state (for result muxing)
//   mem_en          request to memory (combinational)
//   stall           freeze upstream pipeline (combinational)
//   rdata_q         read data captured at completion of a waited access
//   mem_err         sticky timeout flag (0 without MEM_TIMEOUT_EN)
module mem_wait_fsm
  import mem_stage_pkg::*;
#(
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc,
  input  logic          is_store,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output state_e        state,
  output logic          mem_en,
  output logic          stall,
  output logic [DW-1:0] rdata_q,
  output logic          mem_err
);

  state_e state_nxt;
  logic   tmo_hit;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a response always wins over a timeout in the same cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (acc && !mem_ready) state_nxt = ST_WAIT;
      ST_WAIT: if (mem_ready || tmo_hit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request/stall outputs; reset drops any request immediately
  always_comb begin
    mem_en = 1'b0;
    stall  = 1'b0;
    if (!rst) begin
      unique case (state)
        ST_IDLE: begin
          mem_en = acc;
          stall  = acc & ~mem_ready;
        end
        ST_WAIT: begin
          mem_en = 1'b1;
          stall  = 1'b1;
        end
        default: begin
          mem_en = 1'b0;
          stall  = 1'b0;
        end
      endcase
    end
  end

  // Completion data for waited accesses; stores return zero
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (state == ST_WAIT) begin
      if (mem_ready)    rdata_q <= is_store ? '0 : mem_rdata;
      else if (tmo_hit) rdata_q <= TIMEOUT_DATA;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

  logic [CW-1:0] wait_cnt;

  // Counts WAIT cycles, saturating; cleared whenever idle so each access starts at 0
  always_ff @(posedge clk) begin
    if (rst)                                    wait_cnt <= '0;
    else if (state == ST_IDLE)                  wait_cnt <= '0;
    else if (state == ST_WAIT && wait_cnt != '1) wait_cnt <= wait_cnt + CW'(1);
  end

  // This is the TMO_CYC-th WAIT cycle with no response
  assign tmo_hit = (state == ST_WAIT) && !mem_ready &&
                   ((32'(wait_cnt) + 32'd1) >= TMO_CYC);

  // Sticky until reset
  always_ff @(posedge clk) begin
    if (rst)          mem_err <= 1'b0;
    else if (tmo_hit) mem_err <= 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
  assign tmo_hit    = 1'b0;
  assign mem_err    = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage 16-bit pipeline. Sits between EX/MEM
// and MEM_WB, issues loads/stores over a request/ready handshake, stalls
// upstream while an access is outstanding and feeds a bubble to MEM_WB
// during every stall cycle.
// Optional feature macro: MEM_TIMEOUT_EN (access timeout, see mem_wait_fsm).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   EX_*                         instruction/control from EX/MEM register
//   mem_rdata, mem_ready         data-memory response
//   mem_en, mem_wr               request strobe and direction (1=store)
//   mem_addr, mem_wdata          request address/data (zero when idle)
//   MEM_*                        results and control to MEM_WB
//   stall                        freeze PC, IF/ID, ID/EX and EX/MEM
//   mem_err                      sticky timeout flag
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] EX_aluresult,
  input  logic [DW-1:0] EX_wrdata,
  input  logic [DW-1:0] EX_instr,
  input  logic          EX_memread,
  input  logic          EX_memwrite,
  input  logic          EX_RegWrite,
  input  logic          EX_memtoreg,
  input  logic          EX_inval,
  input  logic [RW-1:0] EX_regtowrite,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] MEM_memdata,
  output logic [DW-1:0] MEM_aluresult,
  output logic [DW-1:0] MEM_instr,
  output logic          MEM_RegWrite,
  output logic          MEM_memtoreg,
  output logic          MEM_inval,
  output logic [RW-1:0] MEM_regtowrite,
  output logic          stall,
  output logic          mem_err
);

  logic          acc;
  state_e        state;
  logic [DW-1:0] rdata_q;
  mem_req_t      req;

  // Store wins when both memread and memwrite are set
  assign acc = is_access(EX_inval, EX_memread, EX_memwrite);

  mem_wait_fsm #(
    .TMO_CYC (TMO_CYC)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .acc       (acc),
    .is_store  (EX_memwrite),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .state     (state),
    .mem_en    (mem_en),
    .stall     (stall),
    .rdata_q   (rdata_q),
    .mem_err   (mem_err)
  );

  // Request payload straight from EX; upstream holds it stable while stalled
  always_comb begin
    req = '0;
    if (mem_en) begin
      req.wr    = EX_memwrite;
      req.addr  = EX_aluresult[AW-1:0];
      req.wdata = EX_wrdata;
    end
  end

  assign mem_wr    = req.wr;
  assign mem_addr  = req.addr;
  assign mem_wdata = req.wdata;

  // Load result: live data on a zero-wait hit, captured data when released from DONE
  always_comb begin
    MEM_memdata = '0;
    unique case (state)
      ST_IDLE: if (mem_en && mem_ready) MEM_memdata = mem_rdata;
      ST_DONE: MEM_memdata = rdata_q;
      default: MEM_memdata = '0;
    endcase
  end

  assign MEM_aluresult  = EX_aluresult;
  assign MEM_instr      = EX_instr;
  assign MEM_RegWrite   = EX_RegWrite;
  assign MEM_memtoreg   = EX_memtoreg;
  assign MEM_regtowrite = EX_regtowrite;

  // Every stall cycle reaches MEM_WB as a bubble
  assign MEM_inval = EX_inval | stall;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] EX_aluresult, EX_wrdata, EX_instr;
  logic        EX_memread, EX_memwrite, EX_RegWrite, EX_memtoreg, EX_inval;
  logic [3:0]  EX_regtowrite;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] MEM_memdata, MEM_aluresult, MEM_instr;
  logic        MEM_RegWrite, MEM_memtoreg, MEM_inval;
  logic [3:0]  MEM_regtowrite;
  logic        stall, mem_err;

  int n_pass  = 0;
  int n_total = 0;
  logic exp_err = 1'b0;

  typedef struct {
    logic        inval, rd, wr, regw, mtr, ready;
    logic [15:0] alu, wdata, instr, rdata;
    logic [3:0]  rtw;
  } stim_t;

  typedef struct {
    logic        en, wr, stall, inval, chk_md;
    logic [15:0] md;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  mem_stage #(.TMO_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .EX_aluresult(EX_aluresult), .EX_wrdata(EX_wrdata), .EX_instr(EX_instr),
    .EX_memread(EX_memread), .EX_memwrite(EX_memwrite),
    .EX_RegWrite(EX_RegWrite), .EX_memtoreg(EX_memtoreg), .EX_inval(EX_inval),
    .EX_regtowrite(EX_regtowrite),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .MEM_memdata(MEM_memdata), .MEM_aluresult(MEM_aluresult), .MEM_instr(MEM_instr),
    .MEM_RegWrite(MEM_RegWrite), .MEM_memtoreg(MEM_memtoreg), .MEM_inval(MEM_inval),
    .MEM_regtowrite(MEM_regtowrite),
    .stall(stall), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic en, input logic wr, input logic st,
                              input logic inv, input logic [15:0] md, input logic chk_md);
    exp_t e;
    e.en = en; e.wr = wr; e.stall = st; e.inval = inv; e.md = md; e.chk_md = chk_md;
    return e;
  endfunction

  function automatic stim_t mk_stim(input logic inval, input logic rd, input logic wr,
                                    input logic ready, input logic [15:0] alu,
                                    input logic [15:0] wdata, input logic [15:0] rdata);
    stim_t s;
    s.inval = inval; s.rd = rd; s.wr = wr; s.ready = ready;
    s.alu = alu; s.wdata = wdata; s.rdata = rdata;
    s.instr = 16'($urandom); s.regw = 1'($urandom); s.mtr = 1'($urandom);
    s.rtw = 4'($urandom);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    EX_inval = s.inval;  EX_memread = s.rd;  EX_memwrite = s.wr;
    EX_RegWrite = s.regw; EX_memtoreg = s.mtr; EX_regtowrite = s.rtw;
    EX_aluresult = s.alu; EX_wrdata = s.wdata; EX_instr = s.instr;
    mem_ready = s.ready;  mem_rdata = s.rdata;
  endtask

  task automatic check_outs(input string tag, input stim_t s, input exp_t e);
    chk({tag, ".mem_en"}, 32'(mem_en), 32'(e.en));
    chk({tag, ".stall"}, 32'(stall), 32'(e.stall));
    chk({tag, ".MEM_inval"}, 32'(MEM_inval), 32'(e.inval));
    if (e.en) begin
      chk({tag, ".mem_wr"}, 32'(mem_wr), 32'(e.wr));
      chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(s.alu));
      chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(s.wdata));
    end
    if (e.chk_md) chk({tag, ".MEM_memdata"}, 32'(MEM_memdata), 32'(e.md));
    chk({tag, ".pass"},
        {MEM_aluresult, 4'(MEM_regtowrite), MEM_instr[11:0]},
        {s.alu, s.rtw, s.instr[11:0]});
    chk({tag, ".ctl"}, {30'd0, MEM_RegWrite, MEM_memtoreg}, {30'd0, s.regw, s.mtr});
    chk({tag, ".mem_err"}, 32'(mem_err), 32'(exp_err));
  endtask

  // One clock: drive after the rising edge, sample at the falling edge
  task automatic run_cycle(input string tag, input stim_t s, input exp_t e);
    apply(s);
    @(negedge clk);
    check_outs(tag, s, e);
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: one instruction is an access of latency L
  // (ready in its L-th request cycle) or a single pass-through cycle.
  task automatic run_instr(input string tag, input stim_t base, input int lat);
    stim_t s;
    logic  access, store;
    logic [15:0] rd_val;
    access = !base.inval && (base.rd || base.wr);
    store  = base.wr;
    rd_val = 16'($urandom);
    s = base;
    if (!access) begin
      s.ready = 1'($urandom);
      run_cycle(tag, s, mk(1'b0, 1'b0, 1'b0, base.inval, 16'h0, 1'b1));
    end else begin
      for (int i = 0; i < lat; i++) begin
        s.ready = (i == lat - 1);
        s.rdata = (i == lat - 1) ? rd_val : 16'($urandom);
        if (lat == 1)
          run_cycle(tag, s, mk(1'b1, store, 1'b0, 1'b0, rd_val, !store));
        else
          run_cycle(tag, s, mk(1'b1, store, 1'b1, 1'b1, 16'h0, 1'b0));
      end
      if (lat > 1) begin
        s.ready = 1'($urandom);
        s.rdata = 16'($urandom);
        run_cycle(tag, s, mk(1'b0, 1'b0, 1'b0, 1'b0, store ? 16'h0 : rd_val, 1'b1));
      end
    end
  endtask

  initial begin
    vec_t  vecs[6];
    stim_t s;
    stim_t idle;

    // Reset: request suppressed even with a pending load on the inputs
    rst = 1'b1;
    s = mk_stim(1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0, 16'h0);
    apply(s);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset.mem_en", 32'(mem_en), 32'd0);
      chk("reset.stall", 32'(stall), 32'd0);
      chk("reset.MEM_inval", 32'(MEM_inval), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    chk("reset.mem_err", 32'(mem_err), 32'd0);

    // Single-cycle vectors, all leave the stage idle
    vecs[0] = '{s: mk_stim(1'b0, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h2222, 16'h3333),
                e: mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1)};
    vecs[1] = '{s: mk_stim(1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h5555),
                e: mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1)};
    vecs[2] = '{s: mk_stim(1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h1234),
                e: mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1)};
    vecs[3] = '{s: mk_stim(1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 16'hA5A5, 16'h7777),
                e: mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0)};
    vecs[4] = '{s: mk_stim(1'b0, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h5A5A, 16'h8888),
                e: mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0)};
    vecs[5] = '{s: mk_stim(1'b1, 1'b0, 1'b1, 1'b1, 16'h0030, 16'h9999, 16'hAAAA),
                e: mk(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1)};
    for (int i = 0; i < 6; i++) run_cycle($sformatf("vec%0d", i), vecs[i].s, vecs[i].e);

    // Load, 3-cycle latency
    s = mk_stim(1'b0, 1'b1, 1'b0, 1'b0, 16'h0080, 16'h0000, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      s.ready = (i == 2);
      s.rdata = (i == 2) ? 16'hBEEF : 16'h0bad;
      run_cycle($sformatf("ld3.w%0d", i), s, mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0));
    end
    s.ready = 1'b0; s.rdata = 16'h0;
    run_cycle("ld3.done", s, mk(1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b1));

    // Store, 2-cycle latency
    s = mk_stim(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'hA5A5, 16'h0000);
    run_cycle("st2.w0", s, mk(1'b1, 1'b1, 1'b1, 1'b1, 16'h0, 1'b0));
    s.ready = 1'b1; s.rdata = 16'hCAFE;
    run_cycle("st2.w1", s, mk(1'b1, 1'b1, 1'b1, 1'b1, 16'h0, 1'b0));
    s.ready = 1'b0;
    run_cycle("st2.done", s, mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1));

    // Reset on the second WAIT cycle drops the request; late ready is ignored
    s = mk_stim(1'b0, 1'b1, 1'b0, 1'b0, 16'h00C0, 16'h0000, 16'h0000);
    run_cycle("rstw.idle", s, mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0));
    run_cycle("rstw.w1", s, mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0));
    rst = 1'b1;
    run_cycle("rstw.rst", s, mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0));
    rst = 1'b0;
    idle = mk_stim(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 16'h0000, 16'hDEAD);
    run_cycle("rstw.late", idle, mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1));
    idle.ready = 1'b0;
    run_cycle("rstw.after", idle, mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1));
    s = mk_stim(1'b0, 1'b1, 1'b0, 1'b1, 16'h0200, 16'h0000, 16'h4321);
    run_cycle("rstw.zw", s, mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h4321, 1'b1));

    // Random instruction stream against the transaction model
    for (int n = 0; n < 80; n++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: s = mk_stim(1'b0, 1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
        1: s = mk_stim(1'b1, 1'($urandom), 1'($urandom), 1'b0, 16'($urandom),
                       16'($urandom), 16'($urandom));
        2: s = mk_stim(1'b0, 1'b1, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
        default: s = mk_stim(1'b0, 1'($urandom), 1'b1, 1'b0, 16'($urandom),
                             16'($urandom), 16'($urandom));
      endcase
      run_instr($sformatf("rnd%0d", n), s, int'($urandom_range(1, 5)));
    end

`ifdef MEM_TIMEOUT_EN
    // Timeout: one request cycle in IDLE plus four WAIT cycles, then DONE
    s = mk_stim(1'b0, 1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000, 16'h0000);
    for (int i = 0; i < 5; i++)
      run_cycle($sformatf("tmo.w%0d", i), s, mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0));
    exp_err = 1'b1;
    run_cycle("tmo.done", s, mk(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1));
    idle = mk_stim(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    run_cycle("tmo.sticky", idle, mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1));
    rst = 1'b1;
    run_cycle("tmo.rst", idle, mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1));
    rst = 1'b0;
    exp_err = 1'b0;
    run_cycle("tmo.clear", idle, mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage 16-bit pipeline. It sits between the EX/MEM register and MEM_WB and drives all MEM_* inputs of MEM_WB.
- Issues loads and stores to data memory over a request/ready handshake and holds the access until memory responds.
- Stalls the upstream pipeline while an access is outstanding. During a stall it presents a bubble (MEM_inval=1) to MEM_WB, so MEM_WB wen stays tied high.

Parameters:
- DW, 16, data/instruction width
- AW, 16, memory address width (address = EX_aluresult[AW-1:0])
- RW, 4, register index width
- TMO_CYC, 255, max WAIT cycles before timeout (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- EX_aluresult  in  DW  ALU result / memory address
- EX_wrdata  in  DW  store data
- EX_instr  in  DW  instruction word
- EX_memread  in  1  load
- EX_memwrite  in  1  store
- EX_RegWrite, EX_memtoreg, EX_inval  in  1 each  control passthrough; inval=1 marks a bubble
- EX_regtowrite  in  RW  destination register
- mem_rdata  in  DW  read data, valid when mem_ready=1
- mem_ready  in  1  access complete this cycle
- mem_en  out  1  access request
- mem_wr  out  1  1=store, 0=load
- mem_addr, mem_wdata  out  AW/DW  request address/data
- MEM_memdata, MEM_aluresult, MEM_instr  out  DW  to MEM_WB
- MEM_RegWrite, MEM_memtoreg, MEM_inval  out  1  to MEM_WB
- MEM_regtowrite  out  RW  to MEM_WB
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- mem_err  out  1  sticky timeout flag (MEM_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. While rst=1, mem_en=0 and stall=0 combinationally. At the edge: state=IDLE, rdata_q=0, wait_cnt=0, mem_err=0.
- Access condition: acc = ~EX_inval & (EX_memread | EX_memwrite). If memread and memwrite are both 1, the access is treated as a store.
- Request signals: mem_addr, mem_wdata and mem_wr are driven combinationally from EX inputs whenever mem_en=1. Upstream holds the EX inputs stable while stall=1.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If acc=1: mem_en=1.
  - If also mem_ready=1 (zero-wait): access completes this cycle, stall=0, MEM_memdata=mem_rdata, state stays IDLE.
  - If acc=1 and mem_ready=0: stall=1, next state WAIT, wait_cnt cleared.
  - If acc=0: mem_en=0, stall=0, MEM_memdata=0.
- WAIT:
  - mem_en=1 with request held, stall=1, wait_cnt+1 per cycle (saturating).
  - On mem_ready=1: rdata_q<=mem_rdata (stores capture 0), next state DONE. stall stays 1 in that cycle.
- DONE:
  - mem_en=0, stall=0, MEM_memdata=rdata_q; the instruction is released to MEM_WB.
  - Next state is IDLE unconditionally. The next instruction is evaluated in the following cycle, so back-to-back accesses cost at least 2 cycles each when not zero-wait.
- Passthrough: MEM_aluresult, MEM_instr, MEM_RegWrite, MEM_memtoreg and MEM_regtowrite = EX_* combinationally.
- Bubble: MEM_inval = EX_inval | stall, so MEM_WB captures a bubble on every stall cycle.
- mem_ready outside an outstanding access: ignored.
- Reset while in WAIT: FSM returns to IDLE and the request is dropped. The memory model must tolerate an abandoned request.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro defined: if wait_cnt reaches TMO_CYC in WAIT without mem_ready, then rdata_q<=16'hFFFF, mem_err<=1 (sticky until rst), next state DONE.
- Without the macro: no timeout; WAIT persists indefinitely; mem_err is tied 0 and the counter is not instantiated.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'b00, WAIT=2'b01, DONE=2'b10), DW/AW/RW constants, TIMEOUT_DATA=16'hFFFF.
- Sub-module: mem_wait_fsm, holding state, wait_cnt, rdata_q and mem_err. The top level contains only the passthrough and muxing.

Test Plan:
- Zero-wait load, addr 0x0040, mem_ready in the same cycle with rdata 0x1234 -> stall never 1; MEM_memdata=0x1234 and MEM_inval=0 in that cycle.
- Load with 3-cycle latency, rdata 0xBEEF -> stall=1 for 3 cycles with MEM_inval=1; DONE cycle gives MEM_memdata=0xBEEF, stall=0.
- Store addr 0x0010, data 0xA5A5, 2-cycle latency -> mem_en=1, mem_wr=1, addr/data stable during WAIT; stall released in DONE; MEM_memdata=0.
- Bubble with memread=1, EX_inval=1 -> mem_en=0, stall=0, MEM_inval=1.
- rst asserted on the 2nd WAIT cycle -> next cycle state=IDLE, mem_en=0, stall=0; a late mem_ready is ignored.
- MEM_TIMEOUT_EN with TMO_CYC=4 and mem_ready held 0 -> after 4 WAIT cycles: DONE, MEM_memdata=0xFFFF, mem_err=1 until rst.
